seq_mult: RTL
=============

Name: seq_mult

Overview:
- Parametrised, sequential shift-and-add multiplier. It is the clocked successor of the combinational 4x4 `mult` array.
- Operand width is generic. Signed or unsigned mode is selected per operation.
- A valid/ready handshake on both sides lets it sit between pipeline stages in the datapath.
- Fixed latency of one partial product per clock, which trades area for throughput.

Parameters:
- WIDTH, 4, operand width in bits; legal range 2..32. The product is 2*WIDTH bits.
- CNT_W, $clog2(WIDTH+1), step-counter width; derived, never overridden.

Ports:
- clk  input  1  single clock; all state updates on its rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operands a, b and sgn are valid this cycle
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- sgn  input  1  1 = two's-complement operands/product, 0 = unsigned; sampled with operands
- out_valid  output  1  product is valid and held
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  result
- busy  output  1  high in CALC or DONE

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-low on rst_n. While rst_n=0 the block is in IDLE with:
  - in_ready=1, out_valid=0, busy=0
  - product=0, counter=0, accumulator=0
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid&&in_ready the block latches the operands and moves to CALC with counter=0.
  - sgn=1: latch |a| and |b| as WIDTH-bit unsigned magnitudes, plus neg = a[MSB]^b[MSB]. The most-negative value maps to magnitude 2^(WIDTH-1), which fits.
  - sgn=0: latch a and b as-is, neg=0.
- CALC, one step per cycle:
  - If the multiplier LSB is 1, accumulator += multiplicand << counter, with the add 2*WIDTH bits wide.
  - Shift the multiplier right by 1; counter++.
  - At the edge where counter reaches WIDTH, move to DONE. product is loaded with neg ? -acc_final : acc_final, where acc_final includes the last step; all arithmetic is modulo 2^(2*WIDTH).
  - out_valid goes high on that same edge.
- Latency: the accept edge is T. out_valid is first high after edge T+WIDTH. There is no early termination; a zero operand still takes WIDTH cycles.
- DONE:
  - out_valid=1; product is held stable.
  - in_valid is ignored and in_ready=0.
  - On an edge with out_ready=1: out_valid drops, the block returns to IDLE and in_ready=1.
  - out_ready held low keeps the product held indefinitely.
- No back-to-back overlap: a new accept cannot occur on the same edge as the out_ready retire. The earliest new accept is the following edge, so minimum spacing is WIDTH+2 cycles.
- in_valid during CALC or DONE is not consumed; the producer must hold it.
- Operand changes after the accept edge have no effect.
- Reset mid-CALC or mid-DONE aborts immediately and asynchronously to the reset values. The result in flight is discarded.
- The product register is written only on the CALC->DONE edge and is otherwise stable.
- Unsigned full range: (2^W-1)^2 fits 2*WIDTH bits. Signed: the product range is -2^(2W-2)..2^(2W-2) and always fits.

Decomposition:
- Package mult_pkg holds:
  - state enum mult_state_t {IDLE, CALC, DONE}
  - localparam DEFAULT_WIDTH=4
  - function f_abs(value, width-generic via parameter)
- One natural sub-module: mult_sign_mag. It is combinational magnitude/negation, used for operand absolute values and the final conditional negate, instantiated three times.
- FSM, counter and accumulator stay in seq_mult.

Test Plan:
- WIDTH=4, sgn=0, a=13, b=11 -> out_valid after 4 cycles from accept; product=0x8F (143).
- WIDTH=4, sgn=1, a=4'b1101 (-3), b=5 -> product=8'hF1 (-15). Also a=4'b1000, b=4'b1000 (-8*-8) -> product=8'h40.
- Backpressure: out_ready=0 for 10 cycles after out_valid -> product, out_valid and in_ready=0 held. A new in_valid is not accepted until the edge after out_ready=1.
- Reset mid-CALC: assert rst_n=0 two cycles after accepting 15*15 -> immediately product=0, out_valid=0, in_ready=1. Post-reset 2*3 -> 8'h06.
- WIDTH=8, sgn=0, a=255, b=255 -> product=16'hFE01 after 8 cycles. Sweep all 256 4-bit pairs in both modes against a reference model, checking latency=WIDTH every time.
- Zero operand (a=0, b=9) -> still exactly 4 cycles, product=0.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } mult_state_t;

  localparam int DEFAULT_WIDTH = 4;
  localparam int ABS_W = 64;

  // Two's-complement magnitude of the low `width` bits of value.
  function automatic logic [ABS_W-1:0] f_abs(
    input logic [ABS_W-1:0] value,
    input int               width
  );
    logic [ABS_W-1:0] mask;
    if (width >= ABS_W)
      mask = '1;
    else
      mask = (ABS_W'(1) << width) - ABS_W'(1);
    if (value[6'(width-1)])
      f_abs = (~value + ABS_W'(1)) & mask;
    else
      f_abs = value & mask;
  endfunction

endpackage

// File: rtl/mult_sign_mag.sv
// Combinational sign/magnitude helper: absolute value of a
// signed operand, or conditional two's-complement negation.
module mult_sign_mag
  import mult_pkg::*;
#(
  parameter int W = DEFAULT_WIDTH
) (
  input  logic [W-1:0] value,
  input  logic         abs_en,
  input  logic         neg_en,
  output logic [W-1:0] result
);

  always_comb begin
    result = value;
    if (abs_en)
      result = W'(f_abs(ABS_W'(value), W));
    else if (neg_en)
      result = -value;
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential shift-and-add multiplier, one partial product per
// clock, with valid/ready handshakes on both sides.
module seq_mult
  import mult_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  localparam int CNT_W = $clog2(WIDTH+1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               sgn,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic               busy
);

  localparam int PW = 2*WIDTH;

  mult_state_t state;
  mult_state_t state_nx;

  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic             neg;
  logic [PW-1:0]    acc;
  logic [PW-1:0]    acc_nx;
  logic [PW-1:0]    prod_nx;
  logic [WIDTH-1:0] a_mag;
  logic [WIDTH-1:0] b_mag;
  logic             accept;
  logic             last;

  mult_sign_mag #(.W(WIDTH)) u_abs_a (
    .value  (a),
    .abs_en (sgn),
    .neg_en (1'b0),
    .result (a_mag)
  );

  mult_sign_mag #(.W(WIDTH)) u_abs_b (
    .value  (b),
    .abs_en (sgn),
    .neg_en (1'b0),
    .result (b_mag)
  );

  // Final sign fix-up sees the accumulator including the last step.
  mult_sign_mag #(.W(PW)) u_neg_p (
    .value  (acc_nx),
    .abs_en (1'b0),
    .neg_en (neg),
    .result (prod_nx)
  );

  assign accept = in_valid && (state == IDLE);
  assign last   = (cnt == CNT_W'(WIDTH-1));
  assign acc_nx = acc + (mplier[0]
                  ? ({{WIDTH{1'b0}}, mcand} << cnt)
                  : '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid)
          state_nx = CALC;
      end
      CALC: begin
        busy = 1'b1;
        if (last)
          state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready)
          state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      acc     <= '0;
      product <= '0;
    end else if (accept) begin
      cnt    <= '0;
      mcand  <= a_mag;
      mplier <= b_mag;
      neg    <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
      acc    <= '0;
    end else if (state == CALC) begin
      acc    <= acc_nx;
      mplier <= mplier >> 1;
      cnt    <= cnt + CNT_W'(1);
      if (last)
        product <= prod_nx;
    end
  end

endmodule
